// File: rtl/contadores_param.sv
// contadores_param: NUM_CH independent event counters with a registered,
// index-selected readout port driven by a two-state IDLE/READ FSM.
// SAT selects wrap (0) or saturate (1) on overflow; ovf flags are sticky.
// Optional build macro CLEAR_ON_READ_EN: a valid readout clears the channel
// being read (to 1 if that channel also pops in the same cycle).
module contadores_param #(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 5,
  parameter int IDX_W  = 3,
  parameter int SAT    = 0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [NUM_CH-1:0] pop,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  output logic [CNT_W-1:0]  data,
  output logic              valid,
  output logic [NUM_CH-1:0] ovf,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]  cnt_w [NUM_CH];
  logic [NUM_CH-1:0] rd_hit;
  logic [CNT_W-1:0]  data_reg, data_next;
  logic              valid_reg, valid_next;

  // One-hot match of the requested channel; all zero when idx is out of range
  always_comb begin
    rd_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req && (idx == IDX_W'(i))) begin
        rd_hit[i] = 1'b1;
      end
    end
  end

  // Per-channel counter and sticky overflow flag
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             clr;

`ifdef CLEAR_ON_READ_EN
    assign clr = rd_hit[gi];
`else
    assign clr = 1'b0;
`endif

    // Next count: clear-on-read wins over a plain pop; overflow only on pop at all-ones
    always_comb begin
      cnt_next = cnt_reg;
      ovf_next = ovf_reg;
      if (clr) begin
        cnt_next = pop[gi] ? CNT_W'(1) : '0;
      end else if (pop[gi]) begin
        if (&cnt_reg) begin
          ovf_next = 1'b1;
          cnt_next = (SAT != 0) ? cnt_reg : '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end

    // Counter state register; reset discards any pop in the same cycle
    always_ff @(posedge CLK) begin
      if (reset) begin
        cnt_reg <= '0;
        ovf_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_next;
        ovf_reg <= ovf_next;
      end
    end

    assign cnt_w[gi] = cnt_reg;
    assign ovf[gi]   = ovf_reg;
  end

  // FSM next state and readout mux; readout uses the count before this edge
  always_comb begin
    state_next = state_reg;
    valid_next = 1'b0;
    data_next  = '0;
    case (state_reg)
      IDLE:    if (req)  state_next = READ;
      READ:    if (!req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_hit[i]) begin
        valid_next = 1'b1;
        data_next  = cnt_w[i];
      end
    end
  end

  // State and registered readout; reset aborts any pending readout
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;
  assign busy  = (state_reg == READ);

endmodule

// File: tb/tb_contadores_param.sv
// tb_contadores_param: scoreboard bench for contadores_param. Two instances
// (wrap and saturate) share stimulus; expected results are queued as each
// cycle is driven and compared one cycle later.
module tb_contadores_param;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 5;
  localparam int IDX_W  = 3;
  localparam int MAXV   = (1 << CNT_W) - 1;
`ifdef CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] pop;
  logic              req;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  data_w, data_s;
  logic              valid_w, valid_s;
  logic [NUM_CH-1:0] ovf_w, ovf_s;
  logic              busy_w, busy_s;

  always #5 CLK = ~CLK;

  contadores_param #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W), .SAT(0)) dut (
    .CLK(CLK), .reset(reset), .pop(pop), .req(req), .idx(idx),
    .data(data_w), .valid(valid_w), .ovf(ovf_w), .busy(busy_w)
  );

  contadores_param #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W), .SAT(1)) dut_sat (
    .CLK(CLK), .reset(reset), .pop(pop), .req(req), .idx(idx),
    .data(data_s), .valid(valid_s), .ovf(ovf_s), .busy(busy_s)
  );

  typedef struct {
    int valid;
    int data;
    int busy;
    int ovf;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];
  int   m_cnt [2][NUM_CH];
  int   m_ovf [2][NUM_CH];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, queue the expected outputs, then compare after the edge
  task automatic step(input logic r, input logic [NUM_CH-1:0] p, input logic rq, input int ix);
    exp_t e;
    logic [NUM_CH-1:0] ov;
    reset = r;
    pop   = p;
    req   = rq;
    idx   = IDX_W'(ix);
    for (int s = 0; s < 2; s++) begin
      e.valid = (!r && rq && ix < NUM_CH) ? 1 : 0;
      e.data  = (e.valid != 0) ? m_cnt[s][ix] : 0;
      e.busy  = (!r && rq) ? 1 : 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (r) begin
          m_cnt[s][ch] = 0;
          m_ovf[s][ch] = 0;
        end else if (CLR && e.valid != 0 && ix == ch) begin
          m_cnt[s][ch] = p[ch] ? 1 : 0;
        end else if (p[ch]) begin
          if (m_cnt[s][ch] == MAXV) begin
            m_ovf[s][ch] = 1;
            m_cnt[s][ch] = (s == 1) ? MAXV : 0;
          end else begin
            m_cnt[s][ch] = m_cnt[s][ch] + 1;
          end
        end
      end
      for (int ch = 0; ch < NUM_CH; ch++) ov[ch] = (m_ovf[s][ch] != 0);
      e.ovf = int'(ov);
      if (s == 0) q_w.push_back(e);
      else        q_s.push_back(e);
    end
    @(posedge CLK);
    #1;
    if (q_w.size() == 0 || q_s.size() == 0) begin
      chk("sb_empty", 32'd1, 0);
    end else begin
      e = q_w.pop_front();
      chk("wrap_valid", 32'(valid_w), e.valid);
      chk("wrap_data",  32'(data_w),  e.data);
      chk("wrap_busy",  32'(busy_w),  e.busy);
      chk("wrap_ovf",   32'(ovf_w),   e.ovf);
      e = q_s.pop_front();
      chk("sat_valid",  32'(valid_s), e.valid);
      chk("sat_data",   32'(data_s),  e.data);
      chk("sat_busy",   32'(busy_s),  e.busy);
      chk("sat_ovf",    32'(ovf_s),   e.ovf);
    end
    $display("t=%0t rst=%0b pop=%b req=%0b idx=%0d | w: v=%0b d=%0d b=%0b o=%b | s: v=%0b d=%0d b=%0b o=%b",
             $time, r, p, rq, ix, valid_w, data_w, busy_w, ovf_w, valid_s, data_s, busy_s, ovf_s);
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int ch = 0; ch < NUM_CH; ch++) begin
        m_cnt[s][ch] = 0;
        m_ovf[s][ch] = 0;
      end

    // Reset state
    step(1'b1, '0, 1'b1, 0);
    step(1'b1, '1, 1'b1, 4);
    chk("rst_valid", 32'(valid_w), 0);
    chk("rst_busy",  32'(busy_w),  0);

    // Three pops on channel 4, then read it
    for (int i = 0; i < 3; i++) step(1'b0, 5'b10000, 1'b0, 0);
    step(1'b0, '0, 1'b1, 4);
    chk("r030_data",  32'(data_w),  3);
    chk("r030_valid", 32'(valid_w), 1);
    chk("r030_busy",  32'(busy_w),  1);
    step(1'b0, '0, 1'b0, 0);

    // 33 pops on channel 0: wrap gives 1, saturate gives 31, both flag ovf
    step(1'b1, '0, 1'b0, 0);
    for (int i = 0; i < 33; i++) step(1'b0, 5'b00001, 1'b0, 0);
    step(1'b0, '0, 1'b1, 0);
    chk("r031_wrap_data", 32'(data_w),   1);
    chk("r031_sat_data",  32'(data_s),   31);
    chk("r031_wrap_ovf",  32'(ovf_w[0]), 1);
    chk("r031_sat_ovf",   32'(ovf_s[0]), 1);
    step(1'b0, '0, 1'b0, 0);
    chk("r031_ovf_sticky", 32'(ovf_w[0]), 1);

    // Channel i gets i+1 pops, then back-to-back reads of idx 0..5
    step(1'b1, '0, 1'b0, 0);
    for (int c = 0; c < NUM_CH; c++) begin
      logic [NUM_CH-1:0] p;
      for (int ch = 0; ch < NUM_CH; ch++) p[ch] = (c <= ch);
      step(1'b0, p, 1'b0, 0);
    end
    for (int i = 0; i <= NUM_CH; i++) begin
      step(1'b0, '0, 1'b1, i);
      chk("r032_data",  32'(data_w),  (i < NUM_CH) ? i + 1 : 0);
      chk("r032_valid", 32'(valid_w), (i < NUM_CH) ? 1 : 0);
    end
    step(1'b0, '0, 1'b0, 0);

    // Pop on the channel being read in the same cycle
    step(1'b1, '0, 1'b0, 0);
    for (int i = 0; i < 7; i++) step(1'b0, 5'b00100, 1'b0, 0);
    step(1'b0, 5'b00100, 1'b1, 2);
    chk("r033_first", 32'(data_w), 7);
    step(1'b0, '0, 1'b0, 0);
    step(1'b0, '0, 1'b1, 2);
    chk("r033_second", 32'(data_w), CLR ? 1 : 8);

    // Reset during READ aborts the readout and clears every counter
    step(1'b0, '1, 1'b0, 0);
    step(1'b0, '0, 1'b1, 1);
    step(1'b0, '0, 1'b1, 1);
    step(1'b1, '1, 1'b1, 1);
    chk("r034_valid", 32'(valid_w), 0);
    chk("r034_busy",  32'(busy_w),  0);
    for (int i = 0; i < NUM_CH; i++) begin
      step(1'b0, '0, 1'b1, i);
      chk("r034_data", 32'(data_w), 0);
    end
    step(1'b0, '0, 1'b0, 0);

    // Random traffic: simultaneous pops, idx changes every cycle, rare resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 149) == 0), NUM_CH'($urandom),
           ($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
